imem_dmem_arbiter: RTL and testbench

Shares one single-port, synchronous-read block RAM between the instruction-fetch (IF) stage and the memory-access (MEM) stage of the pipelined CPU. It grants at most one RAM access per cycle, gives the older instruction (MEM) priority, returns read data with a one-cycle valid pulse, and raises per-stage stall signals for the hazard/stall logic. It sits between the pipeline registers and the unified instruction/data RAM. Misaligned MEM accesses are rejected without touching the RAM.

---
 rtl/imem_dmem_arbiter.sv | 113 +++++++++++
 tb/tb_imem_dmem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_dmem_arbiter
// Purpose  : Shares one synchronous-read RAM between the IF and MEM stages,
//            with MEM priority and misaligned-access rejection.
// Revision : 1.0
// ============================================================================
module imem_dmem_arbiter #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [31:0]           if_addr,
   output logic                  if_valid,
   output logic [31:0]           if_inst,
   input  logic                  mem_rd,
   input  logic                  mem_wr,
   input  logic [31:0]           mem_addr,
   input  logic [31:0]           mem_wdata,
   input  logic [3:0]            mem_wstrb,
   output logic                  mem_valid,
   output logic [31:0]           mem_rdata,
   output logic                  mem_err,
   output logic                  stall_if,
   output logic                  stall_mem,
   output logic                  ram_en,
   output logic [3:0]            ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata
);

   // owner_q names whose RAM response arrives in the current cycle
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IF   = 2'd1;
   localparam logic [1:0] OWN_MEM  = 2'd2;
   localparam logic [1:0] OWN_ERR  = 2'd3;

   logic [1:0] owner_q, owner_d;
   logic       store_q, store_d;
   logic       w_mem_req;
   logic       w_misaligned;
   logic       w_mem_elig;
   logic       w_if_elig;
   logic       w_unused;

   assign w_mem_req = mem_rd | mem_wr;
   assign w_unused  = ^{if_addr[31:ADDR_WIDTH+2], if_addr[1:0], mem_addr[31:ADDR_WIDTH+2]};

   // Loads are word-only; rd+wr together behaves as a store
   always_comb begin
      w_misaligned = 1'b0;
      if (mem_wr) begin
         if (mem_wstrb == 4'b1111)
            w_misaligned = (mem_addr[1:0] != 2'b00);
         else if (mem_wstrb == 4'b0011 || mem_wstrb == 4'b1100)
            w_misaligned = mem_addr[0];
      end else begin
         w_misaligned = (mem_addr[1:0] != 2'b00);
      end
   end

   assign w_mem_elig = w_mem_req && (owner_q != OWN_MEM) && (owner_q != OWN_ERR);
   assign w_if_elig  = if_req && (owner_q != OWN_IF);

   always_comb begin
      owner_d   = OWN_NONE;
      store_d   = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 4'b0000;
      ram_addr  = '0;
      ram_wdata = '0;
      if (!rst) begin
         if (w_mem_elig) begin
            store_d = mem_wr;
            if (w_misaligned) begin
               owner_d = OWN_ERR;
            end else begin
               owner_d   = OWN_MEM;
               ram_en    = 1'b1;
               ram_we    = mem_wr ? mem_wstrb : 4'b0000;
               ram_addr  = mem_addr[ADDR_WIDTH+1:2];
               ram_wdata = mem_wdata;
            end
         end else if (w_if_elig) begin
            owner_d  = OWN_IF;
            ram_en   = 1'b1;
            ram_addr = if_addr[ADDR_WIDTH+1:2];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= OWN_NONE;
         store_q <= 1'b0;
      end else begin
         owner_q <= owner_d;
         store_q <= store_d;
      end
   end

   assign if_valid  = (owner_q == OWN_IF);
   assign if_inst   = if_valid ? ram_rdata : 32'h0;
   assign mem_valid = (owner_q == OWN_MEM) || (owner_q == OWN_ERR);
   assign mem_err   = (owner_q == OWN_ERR);
   assign mem_rdata = ((owner_q == OWN_MEM) && !store_q) ? ram_rdata : 32'h0;
   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = w_mem_req & ~mem_valid;

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_dmem_arbiter
// Purpose  : Self-checking bench with a behavioural RAM and reference memory.
// Revision : 1.0
// ============================================================================
module tb_imem_dmem_arbiter;

   localparam int ADDR_WIDTH = 14;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  if_req = 1'b0;
   logic [31:0]           if_addr = '0;
   logic                  if_valid;
   logic [31:0]           if_inst;
   logic                  mem_rd = 1'b0;
   logic                  mem_wr = 1'b0;
   logic [31:0]           mem_addr = '0;
   logic [31:0]           mem_wdata = '0;
   logic [3:0]            mem_wstrb = '0;
   logic                  mem_valid;
   logic [31:0]           mem_rdata;
   logic                  mem_err;
   logic                  stall_if;
   logic                  stall_mem;
   logic                  ram_en;
   logic [3:0]            ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [31:0]           ram_wdata;
   logic [31:0]           ram_rdata;

   imem_dmem_arbiter #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_inst(if_inst),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
      .mem_err(mem_err), .stall_if(stall_if), .stall_mem(stall_mem),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 0) return 32'h00A0_0093;
      return 32'h5A00_0000 | (32'(i) * 32'h0001_0101);
   endfunction

   // Behavioural single-port RAM, read-before-write
   logic [31:0] ram [0:255];
   logic        preload = 1'b1;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
         ram_rdata <= 32'h0;
      end else if (ram_en) begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
         ram_rdata <= ram[ram_addr[7:0]];
      end
   end

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   typedef struct {
      logic [1:0]  kind;   // 0 fetch, 1 load, 2 store, 3 rd+wr
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      bit          exp_err;
   } vec_t;

   logic [31:0] ref_mem [0:255];
   logic [31:0] if_q [$];
   exp_t        mem_q [$];
   int          checks = 0;
   int          errors = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Scoreboard: every response pulse pops and compares one expectation
   always @(negedge clk) begin
      exp_t e;
      if (!rst && !preload) begin
         if (if_valid) begin
            if (if_q.size() == 0) chk("if_unexpected_valid", 32'(if_valid), 32'd0);
            else chk("if_inst", if_inst, if_q.pop_front());
         end else begin
            chk("if_inst_idle", if_inst, 32'h0);
         end
         if (mem_valid) begin
            if (mem_q.size() == 0) chk("mem_unexpected_valid", 32'(mem_valid), 32'd0);
            else begin
               e = mem_q.pop_front();
               chk("mem_rdata", mem_rdata, e.data);
               chk("mem_err", 32'(mem_err), 32'(e.err));
            end
         end else begin
            chk("mem_rdata_idle", mem_rdata, 32'h0);
            chk("mem_err_idle", 32'(mem_err), 32'h0);
         end
      end
   end

   task automatic do_if(input logic [31:0] a, input string nm);
      int n;
      if_q.push_back(ref_mem[a[9:2]]);
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = a;
      @(negedge clk);
      chk({nm, " ram_en"}, 32'(ram_en), 32'd1);
      chk({nm, " ram_addr"}, 32'(ram_addr), 32'(a[15:2]));
      chk({nm, " ram_we"}, 32'(ram_we), 32'd0);
      n = 0;
      do begin @(negedge clk); n++; end while (!if_valid && n < 8);
      if (!if_valid) chk({nm, " timeout"}, 32'(if_valid), 32'd1);
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   task automatic do_mem(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input bit exp_err, input string nm);
      int n;
      logic [31:0] d;
      d = 32'h0;
      if (!exp_err && !wr) d = ref_mem[a[9:2]];
      if (!exp_err && wr)
         for (int b = 0; b < 4; b++)
            if (ws[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
      mem_q.push_back('{data: d, err: exp_err});
      @(posedge clk); #1;
      mem_rd = rd; mem_wr = wr; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
      @(negedge clk);
      chk({nm, " ram_en"}, 32'(ram_en), 32'(!exp_err));
      chk({nm, " ram_addr"}, 32'(ram_addr), exp_err ? 32'h0 : 32'(a[15:2]));
      chk({nm, " ram_we"}, 32'(ram_we), (wr && !exp_err) ? 32'(ws) : 32'h0);
      chk({nm, " stall_mem"}, 32'(stall_mem), 32'd1);
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_valid && n < 8);
      if (!mem_valid) chk({nm, " timeout"}, 32'(mem_valid), 32'd1);
      @(posedge clk); #1;
      mem_rd = 1'b0; mem_wr = 1'b0;
   endtask

   vec_t vecs [15];

   initial begin
      vecs[0]  = '{2'd0, 32'h0000_0000, 32'h0,         4'h0, 1'b0};
      vecs[1]  = '{2'd1, 32'h0000_0040, 32'h0,         4'h0, 1'b0};
      vecs[2]  = '{2'd2, 32'h0000_0022, 32'hBEEF_0000, 4'hC, 1'b0};
      vecs[3]  = '{2'd1, 32'h0000_0020, 32'h0,         4'h0, 1'b0};
      vecs[4]  = '{2'd2, 32'h0000_0030, 32'h1234_5678, 4'hF, 1'b0};
      vecs[5]  = '{2'd1, 32'h0000_0030, 32'h0,         4'h0, 1'b0};
      vecs[6]  = '{2'd2, 32'h0000_0033, 32'hAB00_0000, 4'h8, 1'b0};
      vecs[7]  = '{2'd1, 32'h0000_0030, 32'h0,         4'h0, 1'b0};
      vecs[8]  = '{2'd1, 32'h0000_0041, 32'h0,         4'h0, 1'b1};
      vecs[9]  = '{2'd2, 32'h0000_0042, 32'hFFFF_FFFF, 4'hF, 1'b1};
      vecs[10] = '{2'd2, 32'h0000_0021, 32'h0000_1111, 4'h3, 1'b1};
      vecs[11] = '{2'd1, 32'h0000_0020, 32'h0,         4'h0, 1'b0};
      vecs[12] = '{2'd0, 32'h0000_0017, 32'h0,         4'h0, 1'b0};
      vecs[13] = '{2'd3, 32'h0000_0050, 32'hCAFE_F00D, 4'hF, 1'b0};
      vecs[14] = '{2'd1, 32'h0000_0050, 32'h0,         4'h0, 1'b0};
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst if_valid", 32'(if_valid), 32'd0);
      chk("rst mem_valid", 32'(mem_valid), 32'd0);
      chk("rst mem_err", 32'(mem_err), 32'd0);
      chk("rst ram_en", 32'(ram_en), 32'd0);
      chk("rst ram_we", 32'(ram_we), 32'd0);
      chk("rst ram_addr", 32'(ram_addr), 32'd0);
      chk("rst ram_wdata", ram_wdata, 32'd0);
      chk("rst if_inst", if_inst, 32'd0);
      chk("rst mem_rdata", mem_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; preload = 1'b0;

      // Reset in the middle of a fetch discards its response
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h0000_0010;
      @(negedge clk);
      chk("midrst grant ram_en", 32'(ram_en), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst if_valid", 32'(if_valid), 32'd0);
      chk("midrst if_inst", if_inst, 32'd0);
      chk("midrst ram_en", 32'(ram_en), 32'd0);
      chk("midrst ram_addr", 32'(ram_addr), 32'd0);
      if_q.push_back(ref_mem[4]);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("postrst ram_en", 32'(ram_en), 32'd1);
      chk("postrst ram_addr", 32'(ram_addr), 32'd4);
      chk("postrst if_valid", 32'(if_valid), 32'd0);
      @(negedge clk);
      chk("postrst if_valid pulse", 32'(if_valid), 32'd1);
      @(posedge clk); #1;
      if_req = 1'b0;

      // IF alone: one access every other cycle
      repeat (3) if_q.push_back(32'h00A0_0093);
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("ifalone if_valid", 32'(if_valid), 32'(k % 2));
         chk("ifalone stall_if", 32'(stall_if), 32'((k + 1) % 2));
         chk("ifalone ram_en", 32'(ram_en), 32'((k + 1) % 2));
      end
      @(posedge clk); #1;
      if_req = 1'b0;

      for (int i = 0; i < 15; i++) begin
         if (vecs[i].kind == 2'd0)
            do_if(vecs[i].addr, $sformatf("vec%0d", i));
         else
            do_mem(vecs[i].kind[0], vecs[i].kind[1], vecs[i].addr, vecs[i].wdata,
                   vecs[i].wstrb, vecs[i].exp_err, $sformatf("vec%0d", i));
      end

      // Contention: MEM first, IF granted in the MEM response cycle
      mem_q.push_back('{data: ref_mem[16], err: 1'b0});
      if_q.push_back(ref_mem[2]);
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h8; mem_rd = 1'b1; mem_addr = 32'h40;
      @(negedge clk);
      chk("cont N ram_addr", 32'(ram_addr), 32'h10);
      chk("cont N stall_if", 32'(stall_if), 32'd1);
      @(negedge clk);
      chk("cont N+1 mem_valid", 32'(mem_valid), 32'd1);
      chk("cont N+1 ram_en", 32'(ram_en), 32'd1);
      chk("cont N+1 ram_addr", 32'(ram_addr), 32'h2);
      @(posedge clk); #1;
      mem_rd = 1'b0;
      @(negedge clk);
      chk("cont N+2 if_valid", 32'(if_valid), 32'd1);
      chk("cont N+2 ram_en", 32'(ram_en), 32'd0);
      @(posedge clk); #1;
      if_req = 1'b0;

      // Misaligned load does not block IF in the error cycle
      mem_q.push_back('{data: 32'h0, err: 1'b1});
      if_q.push_back(ref_mem[3]);
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'hC; mem_rd = 1'b1; mem_addr = 32'h41;
      @(negedge clk);
      chk("mis N ram_en", 32'(ram_en), 32'd0);
      @(negedge clk);
      chk("mis N+1 mem_err", 32'(mem_err), 32'd1);
      chk("mis N+1 ram_en", 32'(ram_en), 32'd1);
      chk("mis N+1 ram_addr", 32'(ram_addr), 32'h3);
      @(posedge clk); #1;
      mem_rd = 1'b0;
      @(negedge clk);
      chk("mis N+2 if_valid", 32'(if_valid), 32'd1);
      @(posedge clk); #1;
      if_req = 1'b0;

      // Back-to-back loads with IF held: grants MEM, IF, MEM, IF
      mem_q.push_back('{data: ref_mem[8], err: 1'b0});
      mem_q.push_back('{data: ref_mem[9], err: 1'b0});
      if_q.push_back(ref_mem[1]);
      if_q.push_back(ref_mem[1]);
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h4; mem_rd = 1'b1; mem_addr = 32'h20;
      @(negedge clk);
      chk("b2b N ram_addr", 32'(ram_addr), 32'h8);
      @(negedge clk);
      chk("b2b N+1 ram_addr", 32'(ram_addr), 32'h1);
      @(posedge clk); #1;
      mem_addr = 32'h24;
      @(negedge clk);
      chk("b2b N+2 ram_addr", 32'(ram_addr), 32'h9);
      chk("b2b N+2 if_valid", 32'(if_valid), 32'd1);
      @(negedge clk);
      chk("b2b N+3 ram_addr", 32'(ram_addr), 32'h1);
      chk("b2b N+3 mem_valid", 32'(mem_valid), 32'd1);
      @(posedge clk); #1;
      mem_rd = 1'b0;
      @(negedge clk);
      chk("b2b N+4 if_valid", 32'(if_valid), 32'd1);
      chk("b2b N+4 ram_en", 32'(ram_en), 32'd0);
      @(posedge clk); #1;
      if_req = 1'b0;

      repeat (2) @(negedge clk);
      chk("queue_drain", 32'(if_q.size() + mem_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
